// File: rtl/dram_req_arbiter.sv
// Arbitrates N_CLIENTS req/ack clients onto one single-beat AXI master port.
// Define DRAM_ARB_RR_EN for round-robin arbitration; undefined gives fixed priority (lowest index wins).
module dram_req_arbiter #(
    parameter int N_CLIENTS = 2,
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          locked,
    input  logic [N_CLIENTS-1:0]          req,
    input  logic [N_CLIENTS-1:0]          we,
    input  logic [N_CLIENTS*ADDR_W-1:0]   addr,
    input  logic [N_CLIENTS*DATA_W-1:0]   wdata,
    input  logic [N_CLIENTS*DATA_W/8-1:0] wstrb,
    output logic [N_CLIENTS-1:0]          ack,
    output logic [DATA_W-1:0]             rdata,
    output logic                          err,
    output logic [2:0]                    dbg_state,

    output logic [3:0]                    m_axi_awid,
    output logic [ADDR_W-1:0]             m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awlock,
    output logic [3:0]                    m_axi_awcache,
    output logic [2:0]                    m_axi_awprot,
    output logic [3:0]                    m_axi_awqos,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,

    output logic [DATA_W-1:0]             m_axi_wdata,
    output logic [DATA_W/8-1:0]           m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,

    input  logic [3:0]                    m_axi_bid,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,

    output logic [3:0]                    m_axi_arid,
    output logic [ADDR_W-1:0]             m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arlock,
    output logic [3:0]                    m_axi_arcache,
    output logic [2:0]                    m_axi_arprot,
    output logic [3:0]                    m_axi_arqos,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,

    input  logic [3:0]                    m_axi_rid,
    input  logic [DATA_W-1:0]             m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int IDX_W  = $clog2(N_CLIENTS);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_WRESP = 3'd2,
        S_RD    = 3'd3,
        S_RRESP = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]  g_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              aw_pend_q, w_pend_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              cool_q;

    logic              grant;
    logic              grant_found;
    logic [IDX_W-1:0]  grant_idx;

    logic [ADDR_W-1:0] addr_a  [N_CLIENTS];
    logic [DATA_W-1:0] wdata_a [N_CLIENTS];
    logic [STRB_W-1:0] wstrb_a [N_CLIENTS];

    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_unpack
        assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = wdata[i*DATA_W +: DATA_W];
        assign wstrb_a[i] = wstrb[i*STRB_W +: STRB_W];
    end

    // Response ids are implied by the one-in-flight rule, so they are not checked.
    logic unused_ids;
    assign unused_ids = ^{m_axi_bid, m_axi_rid};

`ifdef DRAM_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= IDX_W'(N_CLIENTS - 1);
        end else if (grant) begin
            rr_ptr <= grant_idx;
        end
    end

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cidx;
        cand        = 0;
        cidx        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            cand = int'(rr_ptr) + 1 + k;
            if (cand >= N_CLIENTS) begin
                cand = cand - N_CLIENTS;
            end
            cidx = IDX_W'(cand);
            if (!grant_found && req[cidx]) begin
                grant_found = 1'b1;
                grant_idx   = cidx;
            end
        end
    end
`else
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = N_CLIENTS - 1; k >= 0; k--) begin
            if (req[IDX_W'(k)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(k);
            end
        end
    end
`endif

    // cool_q holds off granting in the IDLE cycle right after DONE, so a client
    // that drops req in response to ack is never granted twice.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (locked && grant_found && !cool_q) begin
                    grant   = 1'b1;
                    state_d = we[grant_idx] ? S_WR : S_RD;
                end
            end
            S_WR: begin
                if ((!aw_pend_q || m_axi_awready) && (!w_pend_q || m_axi_wready)) begin
                    state_d = S_WRESP;
                end
            end
            S_WRESP: if (m_axi_bvalid)  state_d = S_DONE;
            S_RD:    if (m_axi_arready) state_d = S_RRESP;
            S_RRESP: if (m_axi_rvalid)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_q       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            cool_q    <= 1'b0;
        end else begin
            cool_q <= (state_q == S_DONE);
            if (grant) begin
                g_q       <= grant_idx;
                addr_q    <= addr_a[grant_idx];
                wdata_q   <= wdata_a[grant_idx];
                wstrb_q   <= wstrb_a[grant_idx];
                aw_pend_q <= we[grant_idx];
                w_pend_q  <= we[grant_idx];
                err_q     <= 1'b0;
            end
            if (state_q == S_WR) begin
                if (m_axi_awready) aw_pend_q <= 1'b0;
                if (m_axi_wready)  w_pend_q  <= 1'b0;
            end
            if (state_q == S_WRESP && m_axi_bvalid) begin
                err_q <= (m_axi_bresp != 2'b00);
            end
            if (state_q == S_RRESP && m_axi_rvalid) begin
                rdata_q <= m_axi_rdata;
                err_q   <= (m_axi_rresp != 2'b00) | ~m_axi_rlast;
            end
        end
    end

    // Every channel transfers on an edge where valid && ready are both high;
    // valid is never withdrawn and its payload (latched *_q) never changes before that edge.
    assign m_axi_awvalid = (state_q == S_WR) && aw_pend_q;
    assign m_axi_wvalid  = (state_q == S_WR) && w_pend_q;
    assign m_axi_bready  = (state_q == S_WRESP);
    assign m_axi_arvalid = (state_q == S_RD);
    assign m_axi_rready  = (state_q == S_RRESP);

    assign m_axi_awid    = 4'(g_q);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'b100;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'd0;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awqos   = 4'd0;

    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wlast   = 1'b1;

    assign m_axi_arid    = 4'(g_q);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'b100;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;

    assign ack       = (state_q == S_DONE) ? (N_CLIENTS'(1) << g_q) : '0;
    assign err       = err_q && (state_q == S_DONE);
    assign rdata     = rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Directed bench for dram_req_arbiter (2 clients); the AXI slave is driven step by step.
// Arbitration expectations follow DRAM_ARB_RR_EN when it is defined for the build.
module tb_dram_req_arbiter;

    logic         clk;
    logic         rst;
    logic         locked;
    logic [1:0]   req;
    logic [1:0]   we;
    logic [27:0]  c_addr  [2];
    logic [127:0] c_wdata [2];
    logic [15:0]  c_wstrb [2];
    logic [55:0]  addr;
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic [1:0]   ack;
    logic [127:0] rdata;
    logic         err;
    logic [2:0]   dbg_state;

    logic [3:0]   awid;
    logic [27:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awlock;
    logic [3:0]   awcache;
    logic [2:0]   awprot;
    logic [3:0]   awqos;
    logic         awvalid;
    logic         s_awready;
    logic [127:0] m_wdata;
    logic [15:0]  m_wstrb;
    logic         wlast;
    logic         wvalid;
    logic         s_wready;
    logic [3:0]   s_bid;
    logic [1:0]   s_bresp;
    logic         s_bvalid;
    logic         bready;
    logic [3:0]   arid;
    logic [27:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arlock;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic [3:0]   arqos;
    logic         arvalid;
    logic         s_arready;
    logic [3:0]   s_rid;
    logic [127:0] s_rdata;
    logic [1:0]   s_rresp;
    logic         s_rlast;
    logic         s_rvalid;
    logic         rready;

    int checks = 0;
    int errors = 0;

    assign addr  = {c_addr[1], c_addr[0]};
    assign wdata = {c_wdata[1], c_wdata[0]};
    assign wstrb = {c_wstrb[1], c_wstrb[0]};

    dram_req_arbiter dut (
        .clk(clk), .rst(rst), .locked(locked), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .ack(ack), .rdata(rdata), .err(err), .dbg_state(dbg_state),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
        .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awqos(awqos),
        .m_axi_awvalid(awvalid), .m_axi_awready(s_awready),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(s_wready),
        .m_axi_bid(s_bid), .m_axi_bresp(s_bresp), .m_axi_bvalid(s_bvalid),
        .m_axi_bready(bready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
        .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arqos(arqos),
        .m_axi_arvalid(arvalid), .m_axi_arready(s_arready),
        .m_axi_rid(s_rid), .m_axi_rdata(s_rdata), .m_axi_rresp(s_rresp),
        .m_axi_rlast(s_rlast), .m_axi_rvalid(s_rvalid), .m_axi_rready(rready)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One read by client c; ack is expected in the fourth cycle counting the grant cycle.
    task automatic do_read(input int c, input logic [27:0] a, input logic [127:0] d,
                           input logic [1:0] resp, input logic last, input logic exp_err);
        req       = 2'b01 << c;
        we        = 2'b00;
        c_addr[c] = a;
        step();
        check("rd_arvalid", arvalid, 1'b1);
        check("rd_arid", arid, 4'(c));
        check("rd_araddr", araddr, a);
        check("rd_ar_fixed", {arlen, arsize, arburst, arlock, arcache, arprot, arqos},
              {8'd0, 3'b100, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0});
        step();
        check("rd_rready", rready, 1'b1);
        check("rd_no_early_ack", ack, 2'b00);
        s_rvalid = 1'b1;
        s_rdata  = d;
        s_rresp  = resp;
        s_rlast  = last;
        s_rid    = 4'(c);
        step();
        check("rd_ack", ack, 2'b01 << c);
        check("rd_rdata", rdata, d);
        check("rd_err", err, exp_err);
        s_rvalid = 1'b0;
        s_rresp  = 2'b00;
        s_rlast  = 1'b1;
        req      = 2'b00;
        step();
        check("rd_ack_one_cycle", ack, 2'b00);
        step();
    endtask

    initial begin
        int          n;
        logic [1:0]  exp_g;
        logic        seen;

        rst       = 1'b1;
        locked    = 1'b0;
        req       = 2'b00;
        we        = 2'b00;
        c_addr[0] = '0;  c_addr[1] = '0;
        c_wdata[0] = '0; c_wdata[1] = '0;
        c_wstrb[0] = '0; c_wstrb[1] = '0;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        s_bid     = '0;
        s_bresp   = '0;
        s_bvalid  = 1'b0;
        s_arready = 1'b1;
        s_rid     = '0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_rlast   = 1'b1;
        s_rvalid  = 1'b0;

        step();
        step();
        check("rst_state", dbg_state, 3'd0);
        check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'd0);
        check("rst_ack", ack, 2'b00);
        check("rst_err", err, 1'b0);
        check("rst_rdata", rdata, 128'd0);
        rst = 1'b0;

        // requests stay blocked while locked is low
        req  = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen = seen | awvalid | wvalid | arvalid | (|ack);
        end
        check("locked_blocks", seen, 1'b0);
        locked = 1'b1;
        do_read(0, 28'h0000100, 128'hA5A5_0001_DEAD_BEEF_0123_4567_89AB_CDEF, 2'b00, 1'b1, 1'b0);

        // client 1 write: awready delayed 3 cycles, wready immediate, locked drops mid-flight
        c_addr[1]  = 28'h0000240;
        c_wdata[1] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        c_wstrb[1] = 16'h00FF;
        we         = 2'b10;
        req        = 2'b10;
        s_awready  = 1'b0;
        s_wready   = 1'b1;
        step();
        check("wr_both_valid", {awvalid, wvalid}, 2'b11);
        check("wr_awid", awid, 4'd1);
        check("wr_awaddr", awaddr, 28'h0000240);
        check("wr_wstrb", m_wstrb, 16'h00FF);
        check("wr_wdata", m_wdata, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        check("wr_fixed", {awlen, awsize, awburst, awlock, awcache, awprot, awqos, wlast},
              {8'd0, 3'b100, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 1'b1});
        locked = 1'b0;
        step();
        check("wr_w_dropped", {awvalid, wvalid}, 2'b10);
        step();
        check("wr_aw_held", {awvalid, wvalid}, 2'b10);
        s_awready = 1'b1;
        step();
        check("wr_aw_dropped", {awvalid, wvalid, bready}, 3'b001);
        check("wr_no_early_ack", ack, 2'b00);
        step();
        check("wr_wait_b", ack, 2'b00);
        s_bvalid = 1'b1;
        s_bresp  = 2'b00;
        s_bid    = 4'd1;
        step();
        check("wr_ack", ack, 2'b10);
        check("wr_err", err, 1'b0);
        s_bvalid = 1'b0;
        req      = 2'b00;
        we       = 2'b00;
        locked   = 1'b1;
        step();
        step();

        // error responses
        do_read(0, 28'h0000200, 128'h0F0F_0F0F, 2'b10, 1'b1, 1'b1);
        do_read(1, 28'h0000300, 128'hF0F0_F0F0, 2'b00, 1'b0, 1'b1);

        // both clients requesting continuously; last grant so far was client 1
        req = 2'b11;
        we  = 2'b00;
        for (int t = 0; t < 4; t++) begin
`ifdef DRAM_ARB_RR_EN
            exp_g = 2'(t % 2);
`else
            exp_g = 2'd0;
`endif
            n = 0;
            while (!arvalid && n < 8) begin
                step();
                n++;
            end
            check("arb_arvalid", arvalid, 1'b1);
            check("arb_grant", arid, 4'(exp_g));
            step();
            s_rvalid = 1'b1;
            s_rdata  = 128'(t + 16);
            step();
            check("arb_ack", ack, 2'b01 << exp_g);
            check("arb_rdata", rdata, 128'(t + 16));
            s_rvalid = 1'b0;
        end
        req = 2'b00;
        step();
        step();

        // reset while waiting for the write response
        c_addr[0]  = 28'h0000400;
        c_wdata[0] = 128'h77;
        c_wstrb[0] = 16'hFFFF;
        we         = 2'b01;
        req        = 2'b01;
        s_awready  = 1'b1;
        s_wready   = 1'b1;
        step();
        check("rstx_wr", {awvalid, wvalid}, 2'b11);
        step();
        check("rstx_wresp_state", dbg_state, 3'd2);
        check("rstx_bready", bready, 1'b1);
        rst = 1'b1;
        req = 2'b00;
        step();
        check("rstx_state", dbg_state, 3'd0);
        check("rstx_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'd0);
        check("rstx_ack", ack, 2'b00);
        rst = 1'b0;
        step();
        check("rstx_no_ack", ack, 2'b00);
        check("rstx_idle", dbg_state, 3'd0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
